// File: rtl/tl_pkg.sv
// Shared types and address decode helper for the TileLink C-channel demux.
package tl_pkg;

  localparam int MAX_SLV = 16;

  typedef enum logic {
    IDLE,
    BURST
  } dmx_state_e;

  typedef logic [9:0] beat_cnt_t;

  typedef struct packed {
    logic [63:0] address;
    beat_cnt_t   size;
    logic [63:0] data;
  } tl_c_beat_t;

  typedef logic [MAX_SLV-1:0][63:0] addr_tab_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } dec_res_t;

  // Scan from the top so the lowest matching index is the last one written.
  function automatic dec_res_t addr_decode(
    input logic [63:0] addr,
    input addr_tab_t   base,
    input addr_tab_t   mask,
    input int          n
  );
    dec_res_t r;
    r = '0;
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < n && (addr & mask[i]) == base[i]) begin
        r.hit = 1'b1;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_addr_decode.sv
// Combinational region decode, lowest matching slave index wins.
module tl_addr_decode
  import tl_pkg::*;
#(
  parameter int                          SLAVE_NUM = 2,
  parameter logic [SLAVE_NUM-1:0][63:0] ADDR_BASE = '0,
  parameter logic [SLAVE_NUM-1:0][63:0] ADDR_MASK = '0
) (
  input  logic [63:0] addr_i,
  output logic        hit_o,
  output logic [3:0]  idx_o
);

  addr_tab_t base;
  addr_tab_t mask;
  dec_res_t  res;

  always_comb begin
    base = '0;
    mask = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      base[i] = ADDR_BASE[i];
      mask[i] = ADDR_MASK[i];
    end
    res   = addr_decode(addr_i, base, mask, SLAVE_NUM);
    hit_o = res.hit;
    idx_o = res.idx;
  end

endmodule

// File: rtl/tl_demux_c.sv
// C-channel demux with burst route lock; optional error sink
// for unmatched addresses under TL_DEMUX_C_ERR_SINK_EN.
module tl_demux_c
  import tl_pkg::*;
#(
  parameter int                          SLAVE_NUM = 2,
  parameter type                         DATA_T    = tl_c_beat_t,
  parameter logic [SLAVE_NUM-1:0][63:0] ADDR_BASE = '0,
  parameter logic [SLAVE_NUM-1:0][63:0] ADDR_MASK = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  DATA_T                inp_bits_i,
  input  logic                 inp_valid_i,
  output logic                 inp_ready_o,
  output DATA_T                oup_bits_o [SLAVE_NUM],
  output logic [SLAVE_NUM-1:0] oup_valid_o,
  input  logic [SLAVE_NUM-1:0] oup_ready_i,
`ifdef TL_DEMUX_C_ERR_SINK_EN
  output logic                 err_o,
`endif
  output logic                 busy_o
);

  dmx_state_e state_q, state_d;
  logic [3:0] route_q, route_d;
  logic       sink_q, sink_d;
  beat_cnt_t  counter_q, counter_d;

  logic       dec_hit;
  logic [3:0] dec_idx;
  logic [3:0] route_idx;
  logic       route_sink;
  logic       hs;

  tl_addr_decode #(
    .SLAVE_NUM (SLAVE_NUM),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MASK (ADDR_MASK)
  ) u_dec (
    .addr_i (inp_bits_i.address),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    route_idx  = '0;
    route_sink = 1'b0;
    if (state_q == BURST) begin
      route_idx  = route_q;
      route_sink = sink_q;
    end else if (dec_hit) begin
      route_idx = dec_idx;
    end
`ifdef TL_DEMUX_C_ERR_SINK_EN
    else begin
      route_sink = 1'b1;
    end
`endif

    oup_valid_o = '0;
    inp_ready_o = route_sink;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      oup_bits_o[i] = inp_bits_i;
      if (!route_sink && route_idx == 4'(i)) begin
        oup_valid_o[i] = inp_valid_i;
        inp_ready_o    = oup_ready_i[i];
      end
    end
    hs = inp_valid_i & inp_ready_o;

    state_d   = state_q;
    route_d   = route_q;
    sink_d    = sink_q;
    counter_d = counter_q;
    unique case (state_q)
      IDLE: begin
        if (hs && inp_bits_i.size != '0) begin
          state_d   = BURST;
          route_d   = route_idx;
          sink_d    = route_sink;
          counter_d = inp_bits_i.size;
        end
      end
      BURST: begin
        if (hs) begin
          counter_d = counter_q - 1'b1;
          if (counter_q == beat_cnt_t'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      route_q   <= '0;
      sink_q    <= 1'b0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      route_q   <= route_d;
      sink_q    <= sink_d;
      counter_q <= counter_d;
    end
  end

  assign busy_o = (state_q == BURST);

`ifdef TL_DEMUX_C_ERR_SINK_EN
  logic err_q, err_d;

  assign err_d = hs && state_q == IDLE && route_sink;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_tl_demux_c.sv
// Randomized plus directed bench for tl_demux_c against a burst-level model.
module tb_tl_demux_c;
  import tl_pkg::*;

  localparam int N = 2;
  localparam logic [N-1:0][63:0] BASE = {64'h1000, 64'h0};
  localparam logic [N-1:0][63:0] MASK = {64'hF000, 64'hF000};

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  tl_c_beat_t bits;
  logic       v;
  tl_c_beat_t ob [N];
  logic [N-1:0] ov;
  logic [N-1:0] ordy;
  logic       ir;
  logic       busy;
`ifdef TL_DEMUX_C_ERR_SINK_EN
  logic       err;
`endif

  tl_demux_c #(
    .SLAVE_NUM (N),
    .DATA_T    (tl_c_beat_t),
    .ADDR_BASE (BASE),
    .ADDR_MASK (MASK)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .inp_bits_i  (bits),
    .inp_valid_i (v),
    .inp_ready_o (ir),
    .oup_bits_o  (ob),
    .oup_valid_o (ov),
    .oup_ready_i (ordy),
`ifdef TL_DEMUX_C_ERR_SINK_EN
    .err_o       (err),
`endif
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: beats still owed to a locked burst and its target (-1 = sink).
  int rem = 0;
  int lock_tgt = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int dec_ref(input logic [63:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  task automatic cyc(input logic vi, input logic [63:0] a, input int sz,
                     input logic [N-1:0] rd, output bit hs);
    int t;
    logic [N-1:0] ev;
    logic er;
    v = vi;
    bits.address = a;
    bits.size = 10'(sz);
    bits.data = {$urandom, $urandom};
    ordy = rd;
    #2;
    t = (rem > 0) ? lock_tgt : dec_ref(a);
`ifndef TL_DEMUX_C_ERR_SINK_EN
    if (t < 0) t = 0;
`endif
    ev = '0;
    if (vi && t >= 0) ev[t] = 1'b1;
    er = (t < 0) ? 1'b1 : rd[t];
    chk("oup_valid", 64'(ov), 64'(ev));
    chk("inp_ready", 64'(ir), 64'(er));
    chk("busy", 64'(busy), 64'(rem > 0));
    for (int i = 0; i < N; i++)
      chk("bits_addr", ob[i].address ^ ob[i].data, a ^ bits.data);
    hs = vi && er;
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (hs) begin
      if (rem == 0) begin
        exp_err = (t < 0);
        if (sz > 0) begin
          rem = sz;
          lock_tgt = t;
        end
      end else begin
        rem--;
      end
    end
`ifdef TL_DEMUX_C_ERR_SINK_EN
    chk("err", 64'(err), 64'(exp_err));
`endif
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    v = 1'b1;
    bits.address = 64'h1000;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(ov), 64'b10);
`ifdef TL_DEMUX_C_ERR_SINK_EN
    chk("rst_err", 64'(err), 64'd0);
`endif
    #10;
    v = 1'b0;
    rem = 0;
    exp_err = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hs;
    int n;
    v = 1'b0;
    bits = '0;
    ordy = '0;
    #3;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(ov), 64'd0);
    #4;
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    cyc(1, 64'h1040, 0, 2'b10, hs);
    chk("single_hs", 64'(hs), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);

    cyc(1, 64'h0000, 3, 2'b01, hs);
    for (int i = 0; i < 3; i++) cyc(1, 64'h1000, 0, 2'b01, hs);
    chk("burst_done", 64'(busy), 64'd0);

    cyc(1, 64'h1000, 0, 2'b01, hs);
    chk("stall_hs", 64'(hs), 64'd0);
    cyc(1, 64'h1000, 0, 2'b10, hs);
    chk("unstall_hs", 64'(hs), 64'd1);

    cyc(1, 64'h0000, 3, 2'b11, hs);
    cyc(1, 64'h0000, 0, 2'b11, hs);
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();
    cyc(1, 64'h1000, 0, 2'b10, hs);
    chk("post_rst_hs", 64'(hs), 64'd1);

    n = 0;
    cyc(1, 64'h5000, 2, 2'b00, hs);
    n += int'(hs);
    cyc(1, 64'h0000, 0, 2'b00, hs);
    n += int'(hs);
    cyc(1, 64'h0000, 0, 2'b00, hs);
    n += int'(hs);
`ifdef TL_DEMUX_C_ERR_SINK_EN
    chk("sink_beats", 64'(n), 64'd3);
`else
    chk("slv0_stall", 64'(n), 64'd0);
    cyc(1, 64'h5000, 2, 2'b01, hs);
    for (int i = 0; i < 2; i++) cyc(1, 64'h1000, 0, 2'b01, hs);
`endif
    chk("sink_idle", 64'(busy), 64'd0);

    n = 0;
    cyc(1, 64'h0010, 1, 2'b11, hs);
    n += int'(hs);
    cyc(1, 64'h1010, 0, 2'b11, hs);
    n += int'(hs);
    cyc(1, 64'h1020, 1, 2'b11, hs);
    n += int'(hs);
    cyc(1, 64'h0020, 0, 2'b11, hs);
    n += int'(hs);
    chk("b2b_hs", 64'(n), 64'd4);

    cyc(1, 64'h1000, 1023, 2'b11, hs);
    for (int i = 0; i < 1022; i++) cyc(1, 64'h0000, 0, 2'b11, hs);
    chk("long_busy", 64'(busy), 64'd1);
    cyc(1, 64'h0000, 0, 2'b11, hs);
    chk("long_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] a;
      int r;
      r = $urandom_range(0, 2);
      a = {48'h0, (r == 2) ? 4'h5 : 4'(r), 12'($urandom)};
      cyc($urandom_range(0, 3) != 0, a,
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
          2'($urandom), hs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
